// File: rtl/plugin_dispatcher_pkg.sv
// Shared types and constants for the plugin dispatcher (start/busy/done plugin initiator).
package plugin_dispatcher_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } plugin_disp_state_t;

  localparam int PLUGIN_DEFAULT_TIMEOUT = 1024;

  // Counter must be able to hold TIMEOUT_CYCLES itself so it can saturate there.
  function automatic int timeout_cnt_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/plugin_timeout_counter.sv
// Saturating cycle counter for the dispatcher; expired rises once TIMEOUT_CYCLES-1 cycles were counted.
module plugin_timeout_counter
  import plugin_dispatcher_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PLUGIN_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = timeout_cnt_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] count;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          count <= '0;
        end else if (enable && (count != LIMIT)) begin
          count <= count + 1'b1;
        end
      end

      // >= rather than == so a flush on the expiry cycle still times out from DRAIN.
      assign expired = (count >= LAST);
    end
  endgenerate

endmodule

// File: rtl/plugin_dispatcher.sv
// Core-side start/busy/done initiator for one plugin; optional PLUGIN_PERF_COUNTERS_EN adds perf counters.
module plugin_dispatcher
  import plugin_dispatcher_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PLUGIN_DEFAULT_TIMEOUT,
  parameter int RD_WIDTH       = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue,
  input  logic                flush,
  input  logic [31:0]         operand_a,
  input  logic [31:0]         operand_b,
  input  logic [RD_WIDTH-1:0] rd_addr,
  output logic                stall,
  output logic                wb_valid,
  output logic [RD_WIDTH-1:0] wb_rd,
  output logic [31:0]         wb_data,
  output logic                timeout_err,
  output logic                plug_start,
  output logic [31:0]         plug_operand_a,
  output logic [31:0]         plug_operand_b,
  input  logic                plug_busy,
  input  logic                plug_done,
  input  logic [31:0]         plug_result,
`ifdef PLUGIN_PERF_COUNTERS_EN
  output logic [31:0]         perf_ops,
  output logic [31:0]         perf_cycles,
  output logic [15:0]         perf_timeouts,
`endif
  output plugin_disp_state_t  dbg_state
);

  // Handshake: an instruction is taken on any cycle with issue & ~flush while
  // the dispatcher is in IDLE or RESP; stall tells the execute stage to hold.
  plugin_disp_state_t  state;
  logic [RD_WIDTH-1:0] rd_q;
  logic                accept;
  logic                expired;
  logic                in_flight;

  assign dbg_state = state;
  assign in_flight = (state == WAIT) || (state == DRAIN);
  assign accept    = issue && !flush && ((state == IDLE) || (state == RESP));

  assign stall = (state == START) || (state == WAIT) ||
                 (issue && !flush && ((state == IDLE) || (state == RESP) || (state == DRAIN)));

  assign plug_start  = (state == START) && !plug_busy && !flush;
  assign timeout_err = (((state == WAIT) && !flush) || (state == DRAIN)) && !plug_done && expired;

  plugin_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == START),
    .enable (in_flight),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      plug_operand_a <= '0;
      plug_operand_b <= '0;
      rd_q           <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        plug_operand_a <= operand_a;
        plug_operand_b <= operand_b;
        rd_q           <= rd_addr;
      end
      case (state)
        IDLE:  if (accept) state <= START;
        START: begin
          if (flush)           state <= IDLE;
          else if (!plug_busy) state <= WAIT;
        end
        WAIT: begin
          if (plug_done) begin
            if (flush) begin
              state <= IDLE;
            end else begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= plug_result;
              state    <= RESP;
            end
          end else if (flush) begin
            state <= DRAIN;
          end else if (timeout_err) begin
            state <= IDLE;
          end
        end
        // The writeback in RESP is already committed, so flush only blocks a new accept.
        RESP:  state <= accept ? START : IDLE;
        DRAIN: if (plug_done || expired) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLUGIN_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops      <= '0;
      perf_cycles   <= '0;
      perf_timeouts <= '0;
    end else begin
      if (wb_valid)                  perf_ops      <= perf_ops + 1'b1;
      if (in_flight || state == START) perf_cycles <= perf_cycles + 1'b1;
      if (timeout_err)               perf_timeouts <= perf_timeouts + 1'b1;
    end
  end
`endif

endmodule

// File: doc/plugin_dispatcher.md
Name: plugin_dispatcher

Overview:
Core-side initiator for the RS5 plugin start/busy/done accelerator interface, placed between the execute stage and one plugin instance.
- Accepts a plugin instruction (operands plus destination register) and drives a one-cycle start pulse.
- Stalls the pipeline until the plugin reports done, then returns the result as a one-cycle writeback.
- Handles pipeline flush (abandon result) and a bounded timeout (error pulse).

Parameters:
TIMEOUT_CYCLES, 1024, max cycles from start pulse to done before abort; 0 disables timeout
RD_WIDTH, 5, destination register index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
issue  in  1  execute stage presents a plugin instruction this cycle
flush  in  1  pipeline flush; abandon in-flight operation
operand_a  in  32  first source operand
operand_b  in  32  second source operand
rd_addr  in  RD_WIDTH  destination register of issued instruction
stall  out  1  hold execute stage
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  RD_WIDTH  writeback register index
wb_data  out  32  writeback value (plugin result)
timeout_err  out  1  one-cycle pulse on timeout abort
plug_start  out  1  start pulse to plugin
plug_operand_a  out  32  latched operand_a to plugin
plug_operand_b  out  32  latched operand_b to plugin
plug_busy  in  1  plugin busy
plug_done  in  1  plugin done pulse
plug_result  in  32  plugin result, valid with plug_done

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; operand, rd and result registers 0; timeout counter 0.
- States: IDLE, START, WAIT, RESP, DRAIN.
- stall = (state in {START, WAIT}) | (issue & state in {IDLE, RESP, DRAIN}) & ~flush.
  - Stall is high combinationally in the issue cycle.
- IDLE: on issue & ~flush, latch operand_a/b and rd_addr, then go to START. plug_done seen in IDLE is ignored.
- START: plug_start = ~plug_busy.
  - If plug_busy, remain in START.
  - Otherwise pulse start exactly one cycle, clear counter, go to WAIT.
  - plug_operand_a/b are driven from latched registers and are stable from START until leaving WAIT/DRAIN.
- WAIT: counter increments each cycle.
  - plug_done: capture plug_result, go to RESP.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: pulse timeout_err, go to IDLE, no writeback.
- RESP: wb_valid = 1 for one cycle with wb_rd/wb_data from registers; stall low.
  - issue in RESP is accepted (back-to-back): latch, go to START. Otherwise go to IDLE.
- flush in START before pulse: go to IDLE, no start issued.
- flush in WAIT: go to DRAIN.
  - flush the same cycle as plug_done: flush wins, result discarded, go to IDLE.
- DRAIN: wait for plug_done with no writeback, then go to IDLE.
  - The timeout still applies; it pulses timeout_err and goes to IDLE.
  - An issue in DRAIN is held by stall and is not accepted until IDLE.
- Latency: issue at cycle 0 → start at cycle 1 (if not busy) → done at cycle k → wb_valid at cycle k+1.
- Counter width: $clog2(TIMEOUT_CYCLES+1); saturates and never wraps.
- wb_data and wb_rd hold their last values when wb_valid = 0.

Optional Feature:
PLUGIN_PERF_COUNTERS_EN:
- Defined: adds outputs perf_ops (32, completed writebacks), perf_cycles (32, cycles in START/WAIT/DRAIN) and perf_timeouts (16).
  - All counters wrap modulo 2^width and clear on reset.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- RS5_pkg gains plugin_disp_state_t (enum logic [2:0]: IDLE, START, WAIT, RESP, DRAIN) and the constant PLUGIN_DEFAULT_TIMEOUT = 1024.
- One sub-module: plugin_timeout_counter.
  - Inputs: clear, enable. Output: expired.
  - Parameter: TIMEOUT_CYCLES.

Test Plan:
- Fibonacci plugin, issue operand_a=10, rd=5 → one start pulse; stall until wb_valid, wb_rd=5, wb_data=55; stall low in wb cycle.
- operand_a=0, then operand_a=1 back-to-back (second issue in RESP) → wb_data 0 then 1; two start pulses; no idle cycle between.
- Stub plugin never asserting done, TIMEOUT_CYCLES=16 → timeout_err pulse 16 cycles after start; no wb_valid; late plug_done ignored.
- flush two cycles after start of fib(20) → no wb_valid; an issue during DRAIN stalled and started only after plug_done (6765 discarded).
- plug_busy held high when issue arrives → plug_start withheld until busy drops, then single pulse with operands unchanged.
- reset asserted in WAIT → next cycle all outputs 0, state IDLE; subsequent fib(3) returns 2.
